vio_route_tagger: RTL

//  Per-region route-stamping stage on the user-logic side of the vIO switch fabric.

---
 rtl/vio_route_tagger_pkg.sv | 28 ++
 rtl/vio_route_skid.sv | 73 +++++++
 rtl/vio_route_tagger.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vio_route_tagger_pkg.sv
// Package: vio_route_tagger_pkg
// Shared types and constants for the vIO route-stamping stage.
//   VIO_ROUTE_BITS / VIO_DEST_LSB / VIO_DEST_BITS : route word layout
//   vio_route_t      : {dest[3:0], user[9:0]}, the tdest word seen by the switch
//   vio_tag_state_t  : packet-tracking FSM states
//   dest_ok()        : is the route's destination a real switch port
package vio_route_tagger_pkg;

  localparam int VIO_ROUTE_BITS = 14;
  localparam int VIO_DEST_LSB   = 10;
  localparam int VIO_DEST_BITS  = 4;

  typedef struct packed {
    logic [VIO_DEST_BITS-1:0] dest;
    logic [VIO_DEST_LSB-1:0]  user;
  } vio_route_t;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP
  } vio_tag_state_t;

  function automatic logic dest_ok(input vio_route_t r, input int n_ports);
    return int'(r.dest) < n_ports;
  endfunction

endpackage

// File: rtl/vio_route_skid.sv
// Module: vio_route_skid
// Two-entry register slice between the tagger and the switch. Output is
// always taken from a register (head entry); the second entry absorbs the
// beat accepted in the cycle the sink stalls, so the source sees a full
// cycle of warning and throughput stays at one beat per clock.
// Ports:
//   aclk, aresetn            clock, async active-low reset
//   in_valid/in_ready/in_data  upstream side (in_ready = not full)
//   out_valid/out_ready/out_data  downstream side, held stable while stalled
module vio_route_skid #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] buf0_q, buf0_d;
  logic [W-1:0] buf1_q, buf1_d;
  logic         push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = buf0_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    cnt_d  = cnt_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = in_data;
        else               buf1_d = in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; head advances and the new beat queues behind it.
        if (cnt_q == 2'd1) begin
          buf0_d = in_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q  <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
    end
  end

endmodule

// File: rtl/vio_route_tagger.sv
// Module: vio_route_tagger
// Stamps a packet-stable 14-bit route word (switch tdest) onto one vFPGA
// region's outbound AXI4-Stream and discards packets aimed at a port the
// switch does not have.
// Ports:
//   aclk, aresetn                  clock, async active-low reset
//   cfg_route_we/cfg_route_data    write pending route ([13:10] dest, [9:0] user)
//   cfg_route_act                  route latched for the current/last packet
//   s_axis_t*                      region stream in
//   m_axis_t*, m_route             stream to switch, m_route is its tdest
//   drop_cnt                       dropped packets, saturating
//   pkt_cnt, beat_cnt              forwarded packets/beats (only with
//                                  VIO_ROUTE_STATS_EN defined)
// Optional feature macro: VIO_ROUTE_STATS_EN
module vio_route_tagger
  import vio_route_tagger_pkg::*;
#(
  parameter int                      DATA_BITS = 64,
  parameter int                      ID_BITS   = 6,
  parameter int                      N_PORTS   = 12,
  parameter logic [VIO_ROUTE_BITS-1:0] ROUTE_RST = 14'h0000
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      cfg_route_we,
  input  logic [VIO_ROUTE_BITS-1:0] cfg_route_data,
  output logic [VIO_ROUTE_BITS-1:0] cfg_route_act,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [DATA_BITS-1:0]      s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]    s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic [ID_BITS-1:0]        s_axis_tid,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_BITS-1:0]      m_axis_tdata,
  output logic [DATA_BITS/8-1:0]    m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [ID_BITS-1:0]        m_axis_tid,
  output logic [VIO_ROUTE_BITS-1:0] m_route,
  output logic [15:0]               drop_cnt
`ifdef VIO_ROUTE_STATS_EN
  ,
  output logic [31:0]               pkt_cnt,
  output logic [31:0]               beat_cnt
`endif
);

  localparam int PAY_BITS = DATA_BITS + DATA_BITS/8 + 1 + ID_BITS + VIO_ROUTE_BITS;

  vio_tag_state_t state_q, state_d;
  vio_route_t     pending_q, pending_d;
  vio_route_t     active_q, active_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  // Holds s_axis_tready low for the first cycle after reset release.
  logic           rdy_en_q;

  logic                push;
  vio_route_t          push_route;
  logic                skid_ready;
  logic                s_hs;
  logic [PAY_BITS-1:0] skid_in, skid_out;

  assign s_axis_tready = rdy_en_q & ((state_q == DROP) | skid_ready);
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign cfg_route_act = active_q;
  assign drop_cnt      = drop_cnt_q;

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    drop_cnt_d = drop_cnt_q;
    push       = 1'b0;
    push_route = active_q;
    // A write coinciding with a first beat lands in pending only after
    // active has sampled the old pending value below.
    pending_d  = cfg_route_we ? vio_route_t'(cfg_route_data) : pending_q;

    case (state_q)
      IDLE: begin
        if (s_hs) begin
          active_d = pending_q;
          if (dest_ok(pending_q, N_PORTS)) begin
            push       = 1'b1;
            push_route = pending_q;
            state_d    = s_axis_tlast ? IDLE : PASS;
          end else begin
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            state_d = s_axis_tlast ? IDLE : DROP;
          end
        end
      end
      PASS: begin
        if (s_hs) begin
          push = 1'b1;
          if (s_axis_tlast) state_d = IDLE;
        end
      end
      DROP: begin
        if (s_hs && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      pending_q  <= vio_route_t'(ROUTE_RST);
      active_q   <= vio_route_t'(ROUTE_RST);
      drop_cnt_q <= 16'd0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      active_q   <= active_d;
      drop_cnt_q <= drop_cnt_d;
      rdy_en_q   <= 1'b1;
    end
  end

  assign skid_in = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, push_route};

  vio_route_skid #(
    .W(PAY_BITS)
  ) u_skid (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (push),
    .in_ready  (skid_ready),
    .in_data   (skid_in),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (skid_out)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_route} = skid_out;

`ifdef VIO_ROUTE_STATS_EN
  logic        m_hs;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;

  assign m_hs = m_axis_tvalid & m_axis_tready;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (m_hs) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      if (m_axis_tlast) pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_q  <= 32'd0;
      beat_cnt_q <= 32'd0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign beat_cnt = beat_cnt_q;
`endif

endmodule
